layer_driver: RTL and testbench

LAYER_DRIVER -- requirements
Module: layer_driver

---
 rtl/layer_driver_pkg.sv | 20 ++
 rtl/layer_driver_if.sv | 32 +++
 rtl/layer_word_sel.sv | 30 +++
 rtl/layer_driver.sv | 150 +++++++++++++++
 tb/tb_layer_driver.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/layer_driver_pkg.sv
// Shared numeric-format defaults (num_data: Q8.10 words, 32x12 vector) and the
// layer_driver FSM state encoding.
package layer_driver_pkg;

    localparam int DATA_LEN_DEFAULT = 18;
    localparam int N_WORDS_DEFAULT  = 32 * 12;
    localparam int TIMEOUT_DEFAULT  = 4096;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ARM   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } drv_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_driver_if.sv
// Bundle of the upstream stream, layer handshake and downstream stream of layer_driver.
// slave = the driver's view, master = the surrounding system's view.
interface layer_driver_if
    import layer_driver_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEFAULT,
    parameter int N_WORDS  = N_WORDS_DEFAULT
) ();

    logic                         s_valid;
    logic [DATA_LEN-1:0]          s_data;
    logic                         s_ready;
    logic                         load;
    logic [N_WORDS*DATA_LEN-1:0]  d;
    logic                         valid;
    logic [N_WORDS*DATA_LEN-1:0]  q;
    logic                         m_valid;
    logic [DATA_LEN-1:0]          m_data;
    logic                         m_ready;
    logic                         err;

    modport slave (
        input  s_valid, s_data, valid, q, m_ready,
        output s_ready, load, d, m_valid, m_data, err
    );

    modport master (
        output s_valid, s_data, valid, q, m_ready,
        input  s_ready, load, d, m_valid, m_data, err
    );

endinterface

// File: rtl/layer_word_sel.sv
// Result buffer for layer_driver: captures the whole layer result vector in one
// cycle and presents one word of it, selected by index.
module layer_word_sel
    import layer_driver_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEFAULT,
    parameter int N_WORDS  = N_WORDS_DEFAULT,
    parameter int IDX_W    = idx_w(N_WORDS_DEFAULT)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_capture,
    input  logic [N_WORDS*DATA_LEN-1:0]  i_q,
    input  logic [IDX_W-1:0]             i_idx,
    output logic [DATA_LEN-1:0]          o_word
);

    logic [N_WORDS*DATA_LEN-1:0] r_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
        end else if (i_capture) begin
            r_buf <= i_q;
        end
    end

    assign o_word = r_buf[i_idx*DATA_LEN +: DATA_LEN];

endmodule

// File: rtl/layer_driver.sv
// layer_driver: packs N_WORDS streamed words into a layer vector, runs the load/valid
// handshake with the layer, then streams the result back. Watchdog: LAYER_DRIVER_TIMEOUT_EN.
module layer_driver
    import layer_driver_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEFAULT,
    parameter int N_WORDS  = N_WORDS_DEFAULT,
    parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
    input logic           clk,
    input logic           rst_n,
    layer_driver_if.slave bus
);

    localparam int               IDX_W    = idx_w(N_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    if (N_WORDS < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("layer_driver: N_WORDS must be >= 2 and TIMEOUT >= 1");
    end

    drv_state_t                  r_state;
    drv_state_t                  w_next;
    logic [IDX_W-1:0]            r_wr_idx;
    logic [IDX_W-1:0]            r_rd_idx;
    logic [N_WORDS*DATA_LEN-1:0] r_d;
    logic                        r_s_ready;
    logic                        r_load;
    logic                        r_m_valid;
    logic                        w_s_beat;
    logic                        w_m_beat;
    logic                        w_capture;
    logic                        w_timeout;
    logic                        w_err;
    logic [DATA_LEN-1:0]         w_word;

    assign w_s_beat  = (r_state == FILL)  && bus.s_valid && r_s_ready;
    assign w_m_beat  = (r_state == DRAIN) && r_m_valid   && bus.m_ready;
    assign w_capture = (r_state == WAIT)  && bus.valid;

`ifdef LAYER_DRIVER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] r_wdog;
    logic            r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == WAIT && !bus.valid) begin
                r_wdog <= r_wdog + 1'b1;
            end else begin
                r_wdog <= '0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_timeout = (r_state == WAIT) && !bus.valid && (r_wdog == WD_W'(TIMEOUT - 1));
    assign w_err     = r_err;
`else
    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            FILL:  if (w_s_beat && r_wr_idx == LAST_IDX) w_next = ARM;
            // A result still asserted from the previous round must clear before re-arming.
            ARM:   if (!bus.valid) w_next = WAIT;
            WAIT: begin
                if (w_capture) begin
                    w_next = DRAIN;
                end else if (w_timeout) begin
                    w_next = FILL;
                end
            end
            DRAIN: if (w_m_beat && r_rd_idx == LAST_IDX) w_next = FILL;
            default: w_next = FILL;
        endcase
    end

    // Handshake outputs are registered from the next state so they change on the
    // same edge as the state; counters only rewind on a state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_ready <= 1'b0;
            r_load    <= 1'b0;
            r_m_valid <= 1'b0;
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
        end else begin
            r_s_ready <= (w_next == FILL);
            r_load    <= (w_next == WAIT);
            r_m_valid <= (w_next == DRAIN);
            if (w_next != r_state) begin
                r_wr_idx <= '0;
            end else if (w_s_beat) begin
                r_wr_idx <= r_wr_idx + 1'b1;
            end
            if (w_next != r_state) begin
                r_rd_idx <= '0;
            end else if (w_m_beat) begin
                r_rd_idx <= r_rd_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d <= '0;
        end else if (w_s_beat) begin
            r_d[r_wr_idx*DATA_LEN +: DATA_LEN] <= bus.s_data;
        end
    end

    layer_word_sel #(
        .DATA_LEN (DATA_LEN),
        .N_WORDS  (N_WORDS),
        .IDX_W    (IDX_W)
    ) u_word_sel (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_capture (w_capture),
        .i_q       (bus.q),
        .i_idx     (r_rd_idx),
        .o_word    (w_word)
    );

    assign bus.s_ready = r_s_ready;
    assign bus.load    = r_load;
    assign bus.d       = r_d;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = w_word;
    assign bus.err     = w_err;

endmodule

// File: tb/tb_layer_driver.sv
// Bench for layer_driver: table of transaction scenarios with randomized data and
// handshakes, checked against a queue-level model of fill -> layer -> drain.
`timescale 1ns/1ps
module tb_layer_driver;
    import layer_driver_pkg::*;

    localparam int DL = DATA_LEN_DEFAULT;
    localparam int NW = N_WORDS_DEFAULT;
    localparam int VW = NW * DL;
`ifdef LAYER_DRIVER_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = TIMEOUT_DEFAULT;
`endif

    typedef struct {
        int            kind;      // 0: 12 x 1.0 then zeros, 1: random, 2: all ones, 3: ramp
        int            lat;       // layer latency, cycles from load high to valid
        int            rmode;     // m_ready: 0 always, 1 toggle 1-0-1, 2 random (+ valid noise)
        int            gap;       // random idle cycles between input beats
        int            hold;      // cycles a stale valid is held after fill completes
        int            rst_at;    // drain word index at which reset is pulsed (-1: none)
        logic [DL-1:0] mask;      // layer model: q word = d word ^ mask
        int            exp_rise;  // expected cycles to load high
        int            exp_fall;  // expected cycles from valid to load low
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [DL-1:0] words [NW];
    logic [DL-1:0] expw  [NW];
    logic [VW-1:0] exp_d;
    logic [VW-1:0] q_vec;

    layer_driver_if #(.DATA_LEN(DL), .N_WORDS(NW)) bus ();

    layer_driver #(.DATA_LEN(DL), .N_WORDS(NW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #900us;
        $display("FAIL global_time_limit: simulation still running, want finished");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        int first;
        first = -1;
        checks++;
        for (int k = NW - 1; k >= 0; k--) begin
            if (act[k*DL +: DL] !== exp[k*DL +: DL]) first = k;
        end
        if (first >= 0) begin
            errors++;
            $display("FAIL %s: word %0d got 0x%0h, want 0x%0h", name, first,
                     act[first*DL +: DL], exp[first*DL +: DL]);
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int k = 0; k < NW; k++) r[k*DL +: DL] = DL'($urandom);
        return r;
    endfunction

    // Model: beat k lands in d word k; the layer returns d ^ mask; drain emits words in order.
    task automatic build_model(input int kind, input logic [DL-1:0] mask);
        for (int k = 0; k < NW; k++) begin
            case (kind)
                0:       words[k] = (k < 12) ? DL'(18'h00400) : '0;
                1:       words[k] = DL'($urandom);
                2:       words[k] = '1;
                default: words[k] = DL'(k * 37 + 1);
            endcase
            exp_d[k*DL +: DL] = words[k];
            expw[k]           = words[k] ^ mask;
            q_vec[k*DL +: DL] = expw[k];
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, bus.s_ready, 0);
        check({tag, "_load"},    bus.load,    0);
        check({tag, "_m_valid"}, bus.m_valid, 0);
        check({tag, "_m_data"},  bus.m_data,  0);
        check({tag, "_err"},     bus.err,     0);
        check_vec({tag, "_d"},   bus.d,       '0);
    endtask

    task automatic do_fill(input int gap, input int hold);
        int n;
        int bad_rdy;
        n = 0;
        bad_rdy = 0;
        while (bus.s_ready !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check("s_ready_at_fill_start", bus.s_ready, 1);
        for (int k = 0; k < NW; k++) begin
            if (gap != 0 && $urandom_range(0, 3) == 0) begin
                bus.s_valid = 1'b0;
                bus.s_data  = DL'($urandom);
                tick();
            end
            bus.s_valid = 1'b1;
            bus.s_data  = words[k];
            if (bus.s_ready !== 1'b1) bad_rdy++;
            if (hold > 0 && k == NW - 1) begin
                bus.valid = 1'b1;
                bus.q     = rand_vec();
            end
            tick();
        end
        bus.s_valid = 1'b0;
        check("s_ready_during_fill", bad_rdy, 0);
        check("s_ready_low_after_last_beat", bus.s_ready, 0);
        check("load_low_in_arm", bus.load, 0);
    endtask

    task automatic run_txn(input vec_t v);
        int            n;
        int            bad;
        int            bad_data;
        int            bad_stable;
        int            bad_mv;
        int            j;
        int            cyc;
        logic          rdy;
        logic          acc;
        logic          prev_stall;
        logic [DL-1:0] prev_data;

        build_model(v.kind, v.mask);
        do_fill(v.gap, v.hold);

        if (v.hold > 0) begin
            bad = 0;
            for (int i = 0; i < v.hold; i++) begin
                tick();
                if (bus.load !== 1'b0) bad++;
            end
            check("load_low_while_stale_valid", bad, 0);
            bus.valid = 1'b0;
        end

        n = 0;
        do begin
            tick();
            n++;
        end while (bus.load !== 1'b1 && n < 8);
        check("load_rise_delay", n, v.exp_rise);
        check_vec("d_vector", bus.d, exp_d);

        bad = 0;
        for (int i = 0; i < v.lat; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = DL'($urandom);
            tick();
            if (bus.load !== 1'b1 || bus.d !== exp_d) bad++;
        end
        bus.s_valid = 1'b0;
        check("load_and_d_stable_in_wait", bad, 0);

        bus.valid = 1'b1;
        bus.q     = q_vec;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.load === 1'b1 && n < 8);
        check("load_fall_delay", n, v.exp_fall);
        bus.valid = 1'b0;
        bus.q     = rand_vec();
        check("m_valid_at_drain_start", bus.m_valid, 1);

        j = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        bad_data = 0;
        bad_stable = 0;
        bad_mv = 0;
        while (j < NW && cyc < 4 * NW + 16) begin
            case (v.rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.m_ready = rdy;
            if (v.rmode == 2) begin
                bus.valid = 1'($urandom_range(0, 1));
                bus.q     = rand_vec();
            end
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_data  = DL'($urandom);
            if (bus.m_valid !== 1'b1) begin
                bad_mv++;
            end else begin
                if (bus.m_data !== expw[j]) bad_data++;
                if (prev_stall && bus.m_data !== prev_data) bad_stable++;
            end
            if (v.rst_at == j) begin
                bus.m_ready = 1'b0;
                bus.valid   = 1'b0;
                bus.s_valid = 1'b0;
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_outputs("mid_drain_reset");
                tick();
                tick();
                #2;
                rst_n = 1'b1;
                check("s_ready_low_at_release", bus.s_ready, 0);
                tick();
                check("s_ready_after_midrun_reset", bus.s_ready, 1);
                check("m_valid_low_after_midrun_reset", bus.m_valid, 0);
                check("drain_data_before_reset", bad_data, 0);
                return;
            end
            prev_stall = !rdy;
            prev_data  = bus.m_data;
            acc = rdy && (bus.m_valid === 1'b1);
            tick();
            cyc++;
            if (acc) j++;
        end
        bus.m_ready = 1'b0;
        bus.valid   = 1'b0;
        bus.s_valid = 1'b0;
        check("drain_words_accepted", j, NW);
        check("drain_data_in_order", bad_data, 0);
        check("m_data_stable_when_stalled", bad_stable, 0);
        check("m_valid_held_in_drain", bad_mv, 0);
        check("m_valid_low_after_drain", bus.m_valid, 0);
        check("s_ready_high_after_drain", bus.s_ready, 1);
        check_vec("d_retained_after_drain", bus.d, exp_d);
        check("err_low", bus.err, 0);
    endtask

`ifdef LAYER_DRIVER_TIMEOUT_EN
    task automatic timeout_seq();
        int bad;
        bad = 0;
        build_model(1, '0);
        do_fill(0, 0);
        tick();
        check("wd_load_rise", bus.load, 1);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.load !== 1'b1 || bus.err !== 1'b0) bad++;
        end
        check("wd_quiet_before_timeout", bad, 0);
        tick();
        check("wd_err_set", bus.err, 1);
        check("wd_load_dropped", bus.load, 0);
        check("wd_s_ready_back", bus.s_ready, 1);
        check_vec("wd_d_retained", bus.d, exp_d);
        tick();
        tick();
        check("wd_err_sticky", bus.err, 1);
    endtask
`endif

    initial begin
        vec_t tbl [7];

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.valid   = 1'b0;
        bus.q       = '0;
        bus.m_ready = 1'b0;

        tbl[0] = '{kind:0, lat:5, rmode:0, gap:0, hold:0, rst_at:-1, mask:'0,           exp_rise:1, exp_fall:1};
        tbl[1] = '{kind:0, lat:5, rmode:1, gap:0, hold:0, rst_at:-1, mask:'0,           exp_rise:1, exp_fall:1};
        tbl[2] = '{kind:1, lat:3, rmode:2, gap:1, hold:0, rst_at:-1, mask:DL'($urandom), exp_rise:1, exp_fall:1};
        tbl[3] = '{kind:2, lat:1, rmode:0, gap:0, hold:3, rst_at:-1, mask:18'h2AAAA,    exp_rise:1, exp_fall:1};
        tbl[4] = '{kind:1, lat:7, rmode:2, gap:0, hold:0, rst_at:100, mask:DL'($urandom), exp_rise:1, exp_fall:1};
        tbl[5] = '{kind:3, lat:2, rmode:1, gap:1, hold:0, rst_at:-1, mask:'0,           exp_rise:1, exp_fall:1};
        tbl[6] = '{kind:1, lat:0, rmode:2, gap:1, hold:1, rst_at:-1, mask:DL'($urandom), exp_rise:1, exp_fall:1};

        repeat (3) @(posedge clk);
        #3;
        check_reset_outputs("por");
        rst_n = 1'b1;
        check("s_ready_before_first_clock", bus.s_ready, 0);
        tick();
        check("s_ready_after_release", bus.s_ready, 1);

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

`ifdef LAYER_DRIVER_TIMEOUT_EN
        timeout_seq();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
